// File: rtl/axi_stream_strip_header.sv
// Removes the leading header bytes from each AXI-Stream packet, presents them on a
// separate header channel and re-aligns the remaining payload to the MSB byte lane.
module axi_stream_strip_header #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    output logic                    runt_err
);

    localparam int unsigned W     = DATA_BYTE_WD;
    localparam int unsigned CNT_W = BYTE_CNT_WD + 1;
    localparam int unsigned DW2   = 2 * DATA_WD;
    localparam int unsigned KW2   = 2 * W;

    localparam logic [1:0] S_SOF   = 2'd0;
    localparam logic [1:0] S_BODY  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // Byte-enable to bit-mask expansion; keep bit i covers data bits [8i +: 8].
    function automatic logic [DATA_WD-1:0] f_expand(input logic [W-1:0] keep);
        logic [DATA_WD-1:0] mask;
        mask = '0;
        for (int i = 0; i < int'(W); i++) begin
            mask[i*8 +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_h;
    logic [DATA_WD-1:0] r_res_data;
    logic [W-1:0]       r_res_keep;
    logic               r_vo;
    logic [DATA_WD-1:0] r_do;
    logic [W-1:0]       r_ko;
    logic               r_lo;
    logic               r_vh;
    logic [DATA_WD-1:0] r_dh;
    logic [W-1:0]       r_kh;
    logic               r_runt;

    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_h_nxt;
    logic [DATA_WD-1:0] w_res_data_nxt;
    logic [W-1:0]       w_res_keep_nxt;
    logic               w_vo_nxt;
    logic [DATA_WD-1:0] w_do_nxt;
    logic [W-1:0]       w_ko_nxt;
    logic               w_lo_nxt;
    logic               w_vh_nxt;
    logic [DATA_WD-1:0] w_dh_nxt;
    logic [W-1:0]       w_kh_nxt;
    logic               w_runt_nxt;

    logic               w_slot_free;
    logic               w_hdr_free;
    logic               w_acc;
    logic [DATA_WD-1:0] w_din;
    logic [CNT_W-1:0]   w_h_sof;
    logic [W-1:0]       w_hmask;
    logic [DATA_WD-1:0] w_sof_res_data;
    logic [W-1:0]       w_sof_res_keep;
    logic [DW2-1:0]     w_comb_data;
    logic [KW2-1:0]     w_comb_keep;
    logic [DATA_WD-1:0] w_hi_data;
    logic [DATA_WD-1:0] w_lo_data;
    logic [W-1:0]       w_hi_keep;
    logic [W-1:0]       w_lo_keep;

    assign w_slot_free = !r_vo || ready_out;
    assign w_hdr_free  = !r_vh || ready_header;
    assign ready_in    = (r_state != S_FLUSH) && w_slot_free
                         && ((r_state != S_SOF) || w_hdr_free);
    assign w_acc       = valid_in && ready_in;

    // Disabled lanes are zeroed on entry so every downstream lane with keep=0 is zero.
    assign w_din          = data_in & f_expand(keep_in);
    assign w_h_sof        = CNT_W'(byte_strip_cnt) + CNT_W'(1);
    assign w_hmask        = ~({W{1'b1}} >> w_h_sof);
    assign w_sof_res_data = w_din << {w_h_sof, 3'b000};
    assign w_sof_res_keep = keep_in << w_h_sof;

    // Residue sits in the top R = W-H bytes; the new beat is appended right behind it.
    assign w_comb_data = {r_res_data, {DATA_WD{1'b0}}}
                         | ({{DATA_WD{1'b0}}, w_din} << {r_h, 3'b000});
    assign w_comb_keep = {r_res_keep, {W{1'b0}}}
                         | ({{W{1'b0}}, keep_in} << r_h);
    assign w_hi_data   = w_comb_data[DW2-1 -: DATA_WD];
    assign w_lo_data   = w_comb_data[DATA_WD-1:0];
    assign w_hi_keep   = w_comb_keep[KW2-1 -: W];
    assign w_lo_keep   = w_comb_keep[W-1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_h_nxt        = r_h;
        w_res_data_nxt = r_res_data;
        w_res_keep_nxt = r_res_keep;
        w_vo_nxt       = r_vo && !ready_out;
        w_do_nxt       = r_do;
        w_ko_nxt       = r_ko;
        w_lo_nxt       = r_lo;
        w_vh_nxt       = r_vh && !ready_header;
        w_dh_nxt       = r_dh;
        w_kh_nxt       = r_kh;
        w_runt_nxt     = 1'b0;

        case (r_state)
            S_SOF: begin
                if (w_acc) begin
                    w_vh_nxt       = 1'b1;
                    w_kh_nxt       = keep_in & w_hmask;
                    w_dh_nxt       = w_din & f_expand(w_hmask);
                    w_h_nxt        = w_h_sof;
                    w_res_data_nxt = w_sof_res_data;
                    w_res_keep_nxt = w_sof_res_keep;
                    if (!last_in) begin
                        w_state_nxt = S_BODY;
                    end else if (|w_sof_res_keep) begin
                        w_vo_nxt = 1'b1;
                        w_do_nxt = w_sof_res_data;
                        w_ko_nxt = w_sof_res_keep;
                        w_lo_nxt = 1'b1;
                    end else begin
                        w_runt_nxt = 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (w_acc) begin
                    w_vo_nxt       = 1'b1;
                    w_do_nxt       = w_hi_data;
                    w_res_data_nxt = w_lo_data;
                    w_res_keep_nxt = w_lo_keep;
                    if (!last_in) begin
                        w_ko_nxt = {W{1'b1}};
                        w_lo_nxt = 1'b0;
                    end else if (|w_lo_keep) begin
                        // Tail overflows one beat: full beat now, remainder from FLUSH.
                        w_ko_nxt    = w_hi_keep;
                        w_lo_nxt    = 1'b0;
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_ko_nxt    = w_hi_keep;
                        w_lo_nxt    = 1'b1;
                        w_state_nxt = S_SOF;
                    end
                end
            end
            S_FLUSH: begin
                if (w_slot_free) begin
                    w_vo_nxt    = 1'b1;
                    w_do_nxt    = r_res_data;
                    w_ko_nxt    = r_res_keep;
                    w_lo_nxt    = 1'b1;
                    w_state_nxt = S_SOF;
                end
            end
            default: begin
                w_state_nxt = S_SOF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SOF;
            r_h        <= '0;
            r_res_data <= '0;
            r_res_keep <= '0;
            r_vo       <= 1'b0;
            r_do       <= '0;
            r_ko       <= '0;
            r_lo       <= 1'b0;
            r_vh       <= 1'b0;
            r_dh       <= '0;
            r_kh       <= '0;
            r_runt     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_h        <= w_h_nxt;
            r_res_data <= w_res_data_nxt;
            r_res_keep <= w_res_keep_nxt;
            r_vo       <= w_vo_nxt;
            r_do       <= w_do_nxt;
            r_ko       <= w_ko_nxt;
            r_lo       <= w_lo_nxt;
            r_vh       <= w_vh_nxt;
            r_dh       <= w_dh_nxt;
            r_kh       <= w_kh_nxt;
            r_runt     <= w_runt_nxt;
        end
    end

    assign valid_out    = r_vo;
    assign data_out     = r_do;
    assign keep_out     = r_ko;
    assign last_out     = r_lo;
    assign valid_header = r_vh;
    assign data_header  = r_dh;
    assign keep_header  = r_kh;
    assign runt_err     = r_runt;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed packets plus randomized traffic
// checked against a byte-level packet model (header = first H bytes, payload = rest).
module tb_axi_stream_strip_header;

    localparam int unsigned DATA_WD = 32;
    localparam int unsigned W       = DATA_WD / 8;
    localparam int unsigned CNT_WD  = $clog2(W);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_in;
    logic [DATA_WD-1:0] data_in;
    logic [W-1:0]       keep_in;
    logic               last_in;
    logic               ready_in;
    logic [CNT_WD-1:0]  byte_strip_cnt;
    logic               valid_out;
    logic [DATA_WD-1:0] data_out;
    logic [W-1:0]       keep_out;
    logic               last_out;
    logic               ready_out;
    logic               valid_header;
    logic [DATA_WD-1:0] data_header;
    logic [W-1:0]       keep_header;
    logic               ready_header;
    logic               runt_err;

    axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .byte_strip_cnt (byte_strip_cnt),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_header   (valid_header),
        .data_header    (data_header),
        .keep_header    (keep_header),
        .ready_header   (ready_header),
        .runt_err       (runt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_WD-1:0] data;
        logic [W-1:0]       keep;
        logic               last;
    } beat_t;

    beat_t exp_pay[$];
    beat_t exp_hdr[$];
    beat_t pay_log[$];
    beat_t hdr_log[$];
    logic  post_vo[$];
    logic  post_rdy[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int runt_seen = 0;
    int runt_exp  = 0;
    int idle_max  = 0;
    bit sb_on     = 1'b0;
    bit rand_rdy  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sink readiness: held high for directed tests, randomized otherwise.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            ready_out    = ($urandom_range(0, 3) != 0);
            ready_header = ($urandom_range(0, 2) != 0);
        end else begin
            ready_out    = 1'b1;
            ready_header = 1'b1;
        end
    end

    beat_t prev_pay;
    beat_t prev_hdr;
    bit    pay_stall = 1'b0;
    bit    hdr_stall = 1'b0;

    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (!rst_n) begin
            pay_stall = 1'b0;
            hdr_stall = 1'b0;
        end else begin
            if (pay_stall)
                check("pay_stable", 64'({valid_out, data_out, keep_out, last_out}), 64'({1'b1, prev_pay}));
            if (hdr_stall)
                check("hdr_stable", 64'({valid_header, data_header, keep_header}),
                      64'({1'b1, prev_hdr.data, prev_hdr.keep}));
            cur = '{data: data_out, keep: keep_out, last: last_out};
            if (sb_on && valid_out && ready_out) begin
                pay_log.push_back(cur);
                check("pay_pending", 64'(exp_pay.size() != 0), 64'd1);
                if (exp_pay.size() != 0) begin
                    e = exp_pay.pop_front();
                    check("pay_data", 64'(data_out), 64'(e.data));
                    check("pay_keep", 64'(keep_out), 64'(e.keep));
                    check("pay_last", 64'(last_out), 64'(e.last));
                end
            end
            pay_stall = valid_out && !ready_out;
            prev_pay  = cur;
            cur = '{data: data_header, keep: keep_header, last: 1'b0};
            if (sb_on && valid_header && ready_header) begin
                hdr_log.push_back(cur);
                check("hdr_pending", 64'(exp_hdr.size() != 0), 64'd1);
                if (exp_hdr.size() != 0) begin
                    e = exp_hdr.pop_front();
                    check("hdr_data", 64'(data_header), 64'(e.data));
                    check("hdr_keep", 64'(keep_header), 64'(e.keep));
                end
            end
            hdr_stall = valid_header && !ready_header;
            prev_hdr  = cur;
            if (sb_on && runt_err) runt_seen++;
        end
    end

    // Reference: header = first min(L,H) bytes; payload = bytes H..L-1 cut into W-byte beats.
    task automatic model_push(input byte unsigned pkt[$], input int h);
        beat_t b;
        int    len;
        int    hl;
        int    np;
        len = pkt.size();
        hl  = (len < h) ? len : h;
        b   = '0;
        for (int i = 0; i < hl; i++) begin
            b.data[DATA_WD-1-8*i -: 8] = pkt[i];
            b.keep[W-1-i]              = 1'b1;
        end
        exp_hdr.push_back(b);
        if (len <= h) begin
            runt_exp++;
        end else begin
            np = len - h;
            for (int s = 0; s < np; s += W) begin
                b = '0;
                for (int j = 0; j < int'(W); j++) begin
                    if (s + j < np) begin
                        b.data[DATA_WD-1-8*j -: 8] = pkt[h+s+j];
                        b.keep[W-1-j]              = 1'b1;
                    end
                end
                b.last = (s + int'(W) >= np);
                exp_pay.push_back(b);
            end
        end
    endtask

    task automatic send_beat(input logic [DATA_WD-1:0] d, input logic [W-1:0] k,
                             input logic l, input logic [CNT_WD-1:0] cnt);
        int n;
        n              = 0;
        valid_in       = 1'b1;
        data_in        = d;
        keep_in        = k;
        last_in        = l;
        byte_strip_cnt = cnt;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_in && n < 2000);
        check("in_accept", 64'(ready_in), 64'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = DATA_WD'($urandom);
        post_vo.push_back(valid_out);
        post_rdy.push_back(ready_in);
    endtask

    task automatic send_packet(input byte unsigned pkt[$], input int h, input bit push);
        int nb;
        nb = (pkt.size() + W - 1) / W;
        if (push) model_push(pkt, h);
        for (int bi = 0; bi < nb; bi++) begin
            logic [DATA_WD-1:0] d;
            logic [W-1:0]       k;
            logic [CNT_WD-1:0]  cnt;
            d = DATA_WD'($urandom);
            k = '0;
            for (int j = 0; j < int'(W); j++) begin
                if (bi * W + j < pkt.size()) begin
                    d[DATA_WD-1-8*j -: 8] = pkt[bi*W+j];
                    k[W-1-j]              = 1'b1;
                end
            end
            cnt = (bi == 0) ? CNT_WD'(h - 1) : CNT_WD'($urandom);
            if (idle_max > 0) begin
                repeat ($urandom_range(0, idle_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(d, k, (bi == nb - 1), cnt);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 64'(n < 5000), 64'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        pay_log.delete();
        hdr_log.delete();
        post_vo.delete();
        post_rdy.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte unsigned pkt[$];
        int           r0;
        int           h;
        int           len;

        rst_n          = 1'b0;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        byte_strip_cnt = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_keep_out", 64'(keep_out), 64'd0);
        check("rst_last_out", 64'(last_out), 64'd0);
        check("rst_valid_header", 64'(valid_header), 64'd0);
        check("rst_data_header", 64'(data_header), 64'd0);
        check("rst_keep_header", 64'(keep_header), 64'd0);
        check("rst_runt_err", 64'(runt_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_on = 1'b1;

        // Three full beats, H=2.
        clear_logs();
        pkt.delete();
        for (int i = 0; i < 12; i++) pkt.push_back(8'(i));
        send_packet(pkt, 2, 1'b1);
        drain();
        check("t1_vo_after_b1", 64'(post_vo[0]), 64'd0);
        check("t1_vo_after_b2", 64'(post_vo[1]), 64'd1);
        check("t1_hdr_data", 64'(hdr_log[0].data), 64'h00010000);
        check("t1_hdr_keep", 64'(hdr_log[0].keep), 64'hc);
        check("t1_pay_n", 64'(pay_log.size()), 64'd3);
        check("t1_pay0", 64'(pay_log[0]), 64'({32'h02030405, 4'hf, 1'b0}));
        check("t1_pay1", 64'(pay_log[1]), 64'({32'h06070809, 4'hf, 1'b0}));
        check("t1_pay2", 64'(pay_log[2]), 64'({32'h0A0B0000, 4'hc, 1'b1}));

        // H=3, payload fits a single beat, no flush.
        clear_logs();
        pkt.delete();
        pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC); pkt.push_back(8'hDD);
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
        send_packet(pkt, 3, 1'b1);
        drain();
        check("t2_hdr", 64'({hdr_log[0].data, hdr_log[0].keep}), 64'({32'hAABBCC00, 4'he}));
        check("t2_pay_n", 64'(pay_log.size()), 64'd1);
        check("t2_pay0", 64'(pay_log[0]), 64'({32'hDD112233, 4'hf, 1'b1}));

        // H=1, tail overflows into a flush beat; input stalled during flush.
        clear_logs();
        pkt.delete();
        for (int i = 0; i < 7; i++) pkt.push_back(8'(8'h10 + i));
        send_packet(pkt, 1, 1'b1);
        drain();
        check("t3_rdy_in_flush", 64'(post_rdy[1]), 64'd0);
        check("t3_pay_n", 64'(pay_log.size()), 64'd2);
        check("t3_pay0", 64'(pay_log[0]), 64'({32'h11121314, 4'hf, 1'b0}));
        check("t3_pay1", 64'(pay_log[1]), 64'({32'h15160000, 4'hc, 1'b1}));

        // Runt: two bytes with H=3.
        clear_logs();
        r0 = runt_seen;
        pkt.delete();
        pkt.push_back(8'h01); pkt.push_back(8'h02);
        send_packet(pkt, 3, 1'b1);
        drain();
        check("t4_runt_pulses", 64'(runt_seen - r0), 64'd1);
        check("t4_hdr", 64'({hdr_log[0].data, hdr_log[0].keep}), 64'({32'h01020000, 4'hc}));
        check("t4_pay_n", 64'(pay_log.size()), 64'd0);

        // Randomized traffic with stalls on every channel.
        rand_rdy = 1'b1;
        idle_max = 2;
        for (int p = 0; p < 200; p++) begin
            h   = $urandom_range(1, W);
            len = $urandom_range(1, 3 * W + 2);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            send_packet(pkt, h, 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        idle_max = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rand_runt_count", 64'(runt_seen), 64'(runt_exp));

        // Reset in BODY with a residue held, then a fresh packet.
        sb_on = 1'b0;
        send_beat(32'hA0A1A2A3, 4'hf, 1'b0, 2'd0);
        send_beat(32'hB0B1B2B3, 4'hf, 1'b0, 2'd3);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_valid_out", 64'(valid_out), 64'd0);
        check("mrst_data_out", 64'(data_out), 64'd0);
        check("mrst_keep_out", 64'(keep_out), 64'd0);
        check("mrst_last_out", 64'(last_out), 64'd0);
        check("mrst_valid_header", 64'(valid_header), 64'd0);
        check("mrst_data_header", 64'(data_header), 64'd0);
        check("mrst_keep_header", 64'(keep_header), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mrst_ready_in", 64'(ready_in), 64'd1);
        @(posedge clk);
        #1;
        sb_on = 1'b1;
        clear_logs();
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back(8'(8'h40 + i));
        send_packet(pkt, 2, 1'b1);
        drain();
        check("mrst_hdr", 64'({hdr_log[0].data, hdr_log[0].keep}), 64'({32'h40410000, 4'hc}));
        check("mrst_pay0", 64'(pay_log[0]), 64'({32'h42434445, 4'hf, 1'b1}));

        check("end_pay_empty", 64'(exp_pay.size()), 64'd0);
        check("end_hdr_empty", 64'(exp_hdr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
